byte_stream_checker: RTL and testbench

// - Receive-side counterpart of a constant-byte source: consumes a ready/valid byte

---
 rtl/byte_stream_pkg.sv | 13 +
 rtl/byte_stream_checker.sv | 132 +++++++++++++
 tb/tb_byte_stream_checker.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/byte_stream_pkg.sv
// rtl/byte_stream_pkg.sv - state encoding and default expected byte for the byte stream checker
// The default byte is shared with the matching constant-byte source.
package byte_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } chk_state_t;

   localparam logic [7:0] DEFAULT_EXPECTED = 8'hAB;

endpackage

// File: rtl/byte_stream_checker.sv
// rtl/byte_stream_checker.sv - checks each accepted stream beat against a constant value
// Optional tlast framing check enabled by defining BYTE_STREAM_CHECKER_TLAST_EN.
module byte_stream_checker
   import byte_stream_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] EXPECTED   = DATA_WIDTH'(DEFAULT_EXPECTED),
   parameter int                    NUM_BEATS  = 16,
   localparam int                   CNT_W      = $clog2(NUM_BEATS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [CNT_W-1:0]      match_count,
   output logic [CNT_W-1:0]      mismatch_count,
   output logic [CNT_W-1:0]      first_err_idx,
   output logic                  err_seen,
   output logic                  done,
   output logic                  pass
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_BEATS);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   chk_state_t       state_q, state_d;
   logic             tready_q, tready_d;
   logic [CNT_W-1:0] match_q, match_d;
   logic [CNT_W-1:0] mism_q, mism_d;
   logic [CNT_W-1:0] ferr_q, ferr_d;
   logic             err_q, err_d;
   logic             tlast_err_q, tlast_err_d;

   logic             accept;
   logic             beat_ok;
   logic             last_beat;
   logic             tlast_bad;
   logic [CNT_W-1:0] beat_idx;

   assign accept    = s_axis_tvalid & tready_q;
   assign beat_idx  = match_q + mism_q;
   assign last_beat = (beat_idx == LAST_IDX);
   assign beat_ok   = (s_axis_tdata == EXPECTED);

`ifdef BYTE_STREAM_CHECKER_TLAST_EN
   // tlast must mark exactly the final beat of the run
   assign tlast_bad = (s_axis_tlast != last_beat);
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
   assign tlast_bad    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tready_q    <= 1'b0;
         match_q     <= '0;
         mism_q      <= '0;
         ferr_q      <= '0;
         err_q       <= 1'b0;
         tlast_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tready_q    <= tready_d;
         match_q     <= match_d;
         mism_q      <= mism_d;
         ferr_q      <= ferr_d;
         err_q       <= err_d;
         tlast_err_q <= tlast_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tready_d    = tready_q;
      match_d     = match_q;
      mism_d      = mism_q;
      ferr_d      = ferr_q;
      err_d       = err_q;
      tlast_err_d = tlast_err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               tready_d    = 1'b1;
               match_d     = '0;
               mism_d      = '0;
               ferr_d      = '0;
               err_d       = 1'b0;
               tlast_err_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               // counters saturate at NUM_BEATS rather than wrap
               if (beat_ok) begin
                  if (match_q != MAX_CNT) match_d = match_q + ONE;
               end else begin
                  if (mism_q != MAX_CNT) mism_d = mism_q + ONE;
                  if (!err_q) begin
                     err_d  = 1'b1;
                     ferr_d = beat_idx;
                  end
               end
               if (tlast_bad) tlast_err_d = 1'b1;
               if (last_beat) begin
                  state_d  = ST_DONE;
                  tready_d = 1'b0;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            tready_d = 1'b0;
         end
      endcase
   end

   assign s_axis_tready  = tready_q;
   assign match_count    = match_q;
   assign mismatch_count = mism_q;
   assign first_err_idx  = ferr_q;
   assign err_seen       = err_q;
   assign done           = (state_q == ST_DONE);
   assign pass           = done & ~err_q & ~tlast_err_q;

endmodule

// File: tb/tb_byte_stream_checker.sv
// tb/tb_byte_stream_checker.sv - table-driven bench for byte_stream_checker
// Define BYTE_STREAM_CHECKER_TLAST_EN for both RTL and bench to exercise the tlast check.
module tb_byte_stream_checker;

`ifdef BYTE_STREAM_CHECKER_TLAST_EN
   localparam bit TLAST_ON = 1'b1;
`else
   localparam bit TLAST_ON = 1'b0;
`endif
   localparam int NB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tdata = 8'h00;
   logic       tvalid = 1'b0;
   logic       tlast = 1'b0;
   logic       tready;
   logic [4:0] match_count, mismatch_count, first_err_idx;
   logic       err_seen, done, pass;

   int total = 0;
   int bad = 0;

   byte_stream_checker dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .s_axis_tdata(tdata),
      .s_axis_tvalid(tvalid),
      .s_axis_tready(tready),
      .s_axis_tlast(tlast),
      .match_count(match_count),
      .mismatch_count(mismatch_count),
      .first_err_idx(first_err_idx),
      .err_seen(err_seen),
      .done(done),
      .pass(pass)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bad_mask;
      bit          bubble;
      int          start_at;
      int          tlast_at;
      int          exp_match;
      int          exp_mism;
      int          exp_ferr;
      bit          exp_err;
      bit          exp_pass;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_results(input string tag, input vec_t v);
      check({tag, " match"}, match_count, v.exp_match);
      check({tag, " mismatch"}, mismatch_count, v.exp_mism);
      check({tag, " first_err"}, first_err_idx, v.exp_ferr);
      check({tag, " err_seen"}, err_seen, v.exp_err);
      check({tag, " done"}, done, 1);
      check({tag, " pass"}, pass, v.exp_pass);
      check({tag, " tready"}, tready, 0);
   endtask

   task automatic pulse_start(input string tag);
      int cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!tready && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " tready_up"}, tready, 1);
      check({tag, " cleared_match"}, match_count, 0);
      check({tag, " cleared_mism"}, mismatch_count, 0);
      check({tag, " cleared_done"}, done, 0);
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int    idx;
      int    cyc;
      bit    valid;
      bit    started;
      string tag;
      tag = $sformatf("v%0d", n);
      pulse_start(tag);
      idx = 0;
      cyc = 0;
      started = 1'b0;
      while (idx < NB && cyc < 200) begin
         valid  = v.bubble ? (cyc % 2 == 0) : 1'b1;
         tvalid = valid;
         tdata  = v.bad_mask[idx] ? 8'h00 : 8'hAB;
         tlast  = (idx == v.tlast_at);
         start  = (v.start_at == idx) && !started && valid && tready;
         if (start) started = 1'b1;
         if (valid && tready) idx++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, " beats_taken"}, idx, NB);
      check_results(tag, v);
      // extra offered beats must not be consumed once the run is done
      tvalid = 1'b1;
      tdata  = 8'h00;
      repeat (3) @(negedge clk);
      check_results({tag, " hold"}, v);
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int cyc;
      vecs[0] = '{16'h0000, 1'b0, -1, 15, 16, 0, 0, 1'b0, 1'b1};
      vecs[1] = '{16'h0020, 1'b0, -1, 15, 15, 1, 5, 1'b1, 1'b0};
      vecs[2] = '{16'h0208, 1'b0, -1, 15, 14, 2, 3, 1'b1, 1'b0};
      vecs[3] = '{16'h0000, 1'b1, -1, 15, 16, 0, 0, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 1'b0,  8, 15, 16, 0, 0, 1'b0, 1'b1};
      vecs[5] = '{16'h8001, 1'b0, -1, 15, 14, 2, 0, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 1'b1, -1, 15, 15, 1, 15, 1'b1, 1'b0};
      vecs[7] = '{16'h0000, 1'b0, -1, 10, 16, 0, 0, 1'b0, !TLAST_ON};
      vecs[8] = '{16'h0000, 1'b0, -1, -1, 16, 0, 0, 1'b0, !TLAST_ON};

      repeat (2) @(negedge clk);
      check("rst tready", tready, 0);
      check("rst match", match_count, 0);
      check("rst mismatch", mismatch_count, 0);
      check("rst first_err", first_err_idx, 0);
      check("rst err_seen", err_seen, 0);
      check("rst done", done, 0);
      check("rst pass", pass, 0);
      rst_n = 1'b1;

      tvalid = 1'b1;
      tdata  = 8'hAB;
      repeat (3) @(negedge clk);
      check("idle tready", tready, 0);
      check("idle match", match_count, 0);
      tvalid = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // reset in the middle of a run discards partial results
      pulse_start("mid");
      tvalid = 1'b1;
      tdata  = 8'hAB;
      cyc = 0;
      repeat (7) @(negedge clk);
      check("mid match_before_reset", match_count, 7);
      tvalid = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("mid rst tready", tready, 0);
      check("mid rst match", match_count, 0);
      check("mid rst mismatch", mismatch_count, 0);
      check("mid rst done", done, 0);
      check("mid rst pass", pass, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(vecs[0], 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
